controle_dispensa: RTL

//  Responder end of the keypad selection handshake. Captures the row/column chosen by the digit-entry

---
 rtl/controle_dispensa_pkg.sv | 17 +
 rtl/controle_dispensa_estoque_slots.sv | 34 +++
 rtl/controle_dispensa.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/controle_dispensa_pkg.sv
// rtl/controle_dispensa_pkg.sv - shared FSM state type and erro code constants for controle_dispensa
package controle_dispensa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VALIDA,
    DISPENSA,
    CONFIRMA,
    ERRO
  } estado_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_SLOT    = 2'b01;
  localparam logic [1:0] ERR_VAZIO   = 2'b10;
  localparam logic [1:0] ERR_CREDITO = 2'b11;

endpackage

// File: rtl/controle_dispensa_estoque_slots.sv
// rtl/controle_dispensa_estoque_slots.sv - per-slot stock counters with reload, decrement/clear and zero flag
module estoque_slots #(
  parameter int N_SLOTS   = 16,
  parameter int STOCK_MAX = 7,
  parameter int STOCK_W   = 3,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reload,
  input  logic             dec,
  input  logic             clr,
  input  logic [IDX_W-1:0] idx,
  output logic             zero
);

  logic [STOCK_W-1:0] stock [N_SLOTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SLOTS; i++) stock[i] <= STOCK_W'(STOCK_MAX);
    end else if (reload) begin
      for (int i = 0; i < N_SLOTS; i++) stock[i] <= STOCK_W'(STOCK_MAX);
    end else if (clr) begin
      stock[idx] <= '0;
    end else if (dec && !zero) begin
      stock[idx] <= stock[idx] - 1'b1;
    end
  end

  // An index past the last slot reads as empty so it can never be dispensed.
  assign zero = (int'(idx) < N_SLOTS) ? (stock[idx] == '0) : 1'b1;

endmodule

// File: rtl/controle_dispensa.sv
// rtl/controle_dispensa.sv - keypad selection responder: validates slot/stock/credit, runs motor, debits, pulses ok
// Optional drop-sensor early exit and jam detection enabled by defining SENSOR_QUEDA_EN.
module controle_dispensa
  import controle_dispensa_pkg::*;
#(
  parameter int N_LIN        = 4,
  parameter int N_COL        = 4,
  parameter int SEL_W        = 4,
  parameter int CRED_W       = 8,
  parameter int PRECO        = 50,
  parameter int STOCK_MAX    = 7,
  parameter int MOTOR_CYCLES = 100,
  parameter int ERR_CYCLES   = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sel_valid,
  input  logic [SEL_W-1:0]   linha,
  input  logic [SEL_W-1:0]   coluna,
  input  logic [CRED_W-1:0]  credito,
  input  logic               repor,
  input  logic               sensor_queda,
  output logic               motor_en,
  output logic [SEL_W*2-1:0] motor_slot,
  output logic               debito,
  output logic [CRED_W-1:0]  debito_valor,
  output logic               ok,
  output logic [1:0]         erro,
  output logic               ocupado
);

  localparam int STOCK_W = $clog2(STOCK_MAX + 1);
  localparam int N_SLOTS = N_LIN * N_COL;
  localparam int IDX_W   = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int CNT_MAX = (MOTOR_CYCLES > ERR_CYCLES) ? MOTOR_CYCLES : ERR_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  estado_t           state, nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [1:0]        err_code, code_nxt;
  logic              cap, reload, dec, clr, zero, slot_ok;
  logic [IDX_W-1:0]  idx;
  logic [SEL_W-1:0]  lin_r, col_r;

  assign lin_r   = motor_slot[SEL_W*2-1:SEL_W];
  assign col_r   = motor_slot[SEL_W-1:0];
  assign slot_ok = (int'(lin_r) < N_LIN) && (int'(col_r) < N_COL);
  assign idx     = slot_ok ? IDX_W'(int'(lin_r) * N_COL + int'(col_r)) : '0;

`ifndef SENSOR_QUEDA_EN
  logic unused_sensor;
  assign unused_sensor = sensor_queda;
`endif

  estoque_slots #(
    .N_SLOTS  (N_SLOTS),
    .STOCK_MAX(STOCK_MAX),
    .STOCK_W  (STOCK_W),
    .IDX_W    (IDX_W)
  ) u_estoque (
    .clk   (clk),
    .rst_n (rst_n),
    .reload(reload),
    .dec   (dec),
    .clr   (clr),
    .idx   (idx),
    .zero  (zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      err_code   <= ERR_NONE;
      motor_slot <= '0;
    end else begin
      state    <= nxt;
      cnt      <= cnt_nxt;
      err_code <= code_nxt;
      if (cap) motor_slot <= {linha, coluna};
    end
  end

  always_comb begin
    nxt      = state;
    cnt_nxt  = cnt;
    code_nxt = err_code;
    cap      = 1'b0;
    reload   = 1'b0;
    dec      = 1'b0;
    clr      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        reload  = repor;
        if (sel_valid) begin
          cap = 1'b1;
          nxt = VALIDA;
        end
      end
      VALIDA: begin
        cnt_nxt = '0;
        if (!slot_ok) begin
          nxt      = ERRO;
          code_nxt = ERR_SLOT;
        end else if (zero) begin
          nxt      = ERRO;
          code_nxt = ERR_VAZIO;
        end else if (credito < CRED_W'(PRECO)) begin
          nxt      = ERRO;
          code_nxt = ERR_CREDITO;
        end else begin
          nxt = DISPENSA;
        end
      end
      DISPENSA: begin
        cnt_nxt = cnt + 1'b1;
`ifdef SENSOR_QUEDA_EN
        if (sensor_queda) begin
          nxt     = CONFIRMA;
          cnt_nxt = '0;
        end else if (cnt == CNT_W'(MOTOR_CYCLES - 1)) begin
          // No drop seen within the motor window: the slot is jammed.
          clr      = 1'b1;
          nxt      = ERRO;
          code_nxt = ERR_VAZIO;
          cnt_nxt  = '0;
        end
`else
        if (cnt == CNT_W'(MOTOR_CYCLES - 1)) begin
          nxt     = CONFIRMA;
          cnt_nxt = '0;
        end
`endif
      end
      CONFIRMA: begin
        dec = 1'b1;
        nxt = IDLE;
      end
      ERRO: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_W'(ERR_CYCLES - 1)) begin
          nxt      = IDLE;
          cnt_nxt  = '0;
          code_nxt = ERR_NONE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  assign motor_en     = (state == DISPENSA);
  assign debito       = (state == CONFIRMA);
  assign debito_valor = debito ? CRED_W'(PRECO) : '0;
  assign ok           = (state == CONFIRMA) || ((state == ERRO) && (cnt == CNT_W'(ERR_CYCLES - 1)));
  assign erro         = (state == ERRO) ? err_code : ERR_NONE;
  assign ocupado      = (state != IDLE);

endmodule
